hf_decoder: RTL and testbench
=============================

# hf_decoder

- Serial Huffman decoder, the receive-side counterpart of the 5-symbol Huffman encoder.
- Accepts a code table (the encoder's 20-bit, 4-bit-per-symbol code word plus a per-symbol length vector) and then a serial bitstream, MSB of each code first.
- Emits one symbol index per completed code word, and flags any 4-bit prefix that matches no code.
- Sits downstream of the encoder/link in the HF datapath.

## Interface
- No parameters; symbol count 5, max code length 4, fixed.
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  table load strobe, one cycle
- code_table  in  20  codes: symbol 0 (a) in [19:16], then b, c, d, e; code right-aligned in its nibble
- code_len  in  15  lengths: symbol 0 in [14:12], then b, c, d, e in [2:0]
- bit_valid  in  1  bit_in is valid this cycle
- bit_in  in  1  serial code bit
- out_valid  out  1  one-cycle pulse, symbol decoded
- out_symbol  out  3  decoded index 0..4 (a..e); 0 when out_valid low
- err  out  1  one-cycle pulse, invalid 4-bit prefix
- table_ok  out  1  a table has been loaded since reset

## Operation
- States: IDLE (no table) and RUN.
- Reset leaves the block in IDLE; reset state is given under Timing.
- In IDLE, bit_valid is ignored.
- in_valid in any state:
  - latch code_table and code_len, clear accumulator and count, go to RUN
  - set table_ok=1 the next cycle
- Length rules:
  - len 1..4: symbol active
  - len 0 or 5..7: symbol unused, never matches
- Per accepted bit (RUN, bit_valid=1, in_valid=0):
  - acc_n = {acc[2:0], bit_in}, cnt_n = cnt+1
  - symbol i matches when len_i == cnt_n and acc_n[len_i-1:0] == code_i[len_i-1:0]
  - a match sets out_valid=1 and out_symbol=i, then clears acc and cnt
  - multiple matches (table not prefix-free): lowest index wins
  - no match with cnt_n == 4: err=1, clear acc and cnt, resume decoding at the next bit
  - otherwise store acc_n and cnt_n; no output
- Code bit order: bit len-1 of the nibble is transmitted first.
- The table is not checked for prefix-freeness or Kraft completeness.

## Timing
- Reset values: out_valid=0, out_symbol=0, err=0, table_ok=0, acc=0, cnt=0, stored table=0, state=IDLE.
- Latency: out_valid or err is registered and high exactly one cycle after the clock edge that accepts the final bit.
- Throughput: one bit per cycle, back-to-back symbols with no bubble.
  - A 1-bit code on every cycle gives out_valid on every cycle.
- bit_valid low cycles are gaps: acc and cnt are held, and outputs return to 0.
- in_valid together with bit_valid: the table load wins, the bit is dropped, no out_valid or err that cycle.
- Table reload mid-code: the partial code is discarded silently.
- rst_n low mid-code: the next cycle shows the reset values; the table must be reloaded.
- out_valid and err are never high together.

## Structure
- Shared package holds:
  - HF_NSYM=5, HF_MAXLEN=4, HF_CODE_W=4, HF_LEN_W=3
  - symbol index enum SYM_A..SYM_E (0..4), shared with the encoder
  - state enum {IDLE, RUN}
- One sub-module, hf_code_match: combinational.
  - inputs: acc_n, cnt_n, one code nibble, one length
  - output: match bit
  - instantiated 5 times
- Top-level contents:
  - table registers, accumulator/count, FSM
  - priority encoder over the 5 match bits
  - output registers

## Test plan
- Reference table: code_table=20'h026EF, code_len=15'h14E4, giving a=0, b=10, c=110, d=1110, e=1111.
- Load the reference table, then stream 1,0,0,1,1,1,1,1,1,0 on consecutive cycles:
  - out_valid pulses with out_symbol 1, 0, 4, 2
  - the pulses follow the edges accepting bits 2, 3, 7 and 10
  - err stays 0
- Reference table, stream 0 for 6 cycles: out_valid high 6 consecutive cycles, out_symbol=0.
- Load code_len=15'h14E0 (e unused), stream 1,1,1,1: err pulses one cycle after bit 4, no out_valid; then bit 0 gives out_symbol=0.
- Reference table, send 1,1, then in_valid with the same table while bit_valid=1, bit_in=0, then 0:
  - no output from the discarded prefix
  - final 0 gives out_symbol=0
- Bits before any load are ignored (no out_valid, table_ok=0).
- Reference table, send 1,1,1 with idle gaps of 3 cycles between bits, then 0: out_symbol=3 one cycle after the 0.
- rst_n low for one cycle after bits 1,1: all outputs 0, table_ok=0, and later bits are ignored until reload.

Source files
------------

// File: rtl/hf_pkg.sv
// Shared constants and enums for the HF Huffman encoder/decoder pair.
// Symbol indices are common to both ends of the link.
package hf_pkg;

    localparam int HF_NSYM   = 5;
    localparam int HF_MAXLEN = 4;
    localparam int HF_CODE_W = 4;
    localparam int HF_LEN_W  = 3;

    typedef enum logic [2:0] {
        SYM_A = 3'd0,
        SYM_B = 3'd1,
        SYM_C = 3'd2,
        SYM_D = 3'd3,
        SYM_E = 3'd4
    } hf_sym_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } hf_state_e;

endpackage

// File: rtl/hf_code_match.sv
// Compares the candidate accumulator against one table entry.
// A length outside 1..4 marks the symbol unused, so it never matches.
module hf_code_match
    import hf_pkg::*;
(
    input  logic [HF_CODE_W-1:0] acc_n,
    input  logic [HF_LEN_W-1:0]  cnt_n,
    input  logic [HF_CODE_W-1:0] code,
    input  logic [HF_LEN_W-1:0]  len,
    output logic                 match
);

    logic [HF_CODE_W-1:0] mask;

    always_comb begin
        mask = '0;
        case (len)
            3'd1:    mask = 4'b0001;
            3'd2:    mask = 4'b0011;
            3'd3:    mask = 4'b0111;
            3'd4:    mask = 4'b1111;
            default: mask = 4'b0000;
        endcase
        match = (mask != '0) && (len == cnt_n) && ((acc_n & mask) == (code & mask));
    end

endmodule

// File: rtl/hf_decoder.sv
// Serial Huffman decoder: loads a 5-symbol code table, then consumes one
// bit per cycle (code MSB first) and emits a symbol index or an error pulse.
module hf_decoder
    import hf_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    input  logic [HF_NSYM*HF_CODE_W-1:0]  code_table,
    input  logic [HF_NSYM*HF_LEN_W-1:0]   code_len,
    input  logic                          bit_valid,
    input  logic                          bit_in,
    output logic                          out_valid,
    output logic [2:0]                    out_symbol,
    output logic                          err,
    output logic                          table_ok
);

    hf_state_e                     state_q;
    logic [HF_NSYM*HF_CODE_W-1:0]  code_q;
    logic [HF_NSYM*HF_LEN_W-1:0]   len_q;
    logic [HF_CODE_W-1:0]          acc_q;
    logic [HF_LEN_W-1:0]           cnt_q;

    logic [HF_CODE_W-1:0]          acc_n;
    logic [HF_LEN_W-1:0]           cnt_n;
    logic [HF_NSYM-1:0]            match;
    logic                          hit;
    hf_sym_e                       hit_idx;

    assign acc_n = {acc_q[HF_CODE_W-2:0], bit_in};
    assign cnt_n = cnt_q + 3'd1;

    // Symbol 0 sits in the most significant nibble / length field.
    for (genvar g = 0; g < HF_NSYM; g++) begin : g_match
        hf_code_match u_match (
            .acc_n (acc_n),
            .cnt_n (cnt_n),
            .code  (code_q[(HF_NSYM-1-g)*HF_CODE_W +: HF_CODE_W]),
            .len   (len_q[(HF_NSYM-1-g)*HF_LEN_W +: HF_LEN_W]),
            .match (match[g])
        );
    end

    // Descending scan so the lowest matching index overwrites the others.
    always_comb begin
        hit     = 1'b0;
        hit_idx = SYM_A;
        for (int i = HF_NSYM - 1; i >= 0; i--) begin
            if (match[i]) begin
                hit     = 1'b1;
                hit_idx = hf_sym_e'(i[2:0]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            code_q     <= '0;
            len_q      <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            out_valid  <= 1'b0;
            out_symbol <= '0;
            err        <= 1'b0;
            table_ok   <= 1'b0;
        end else begin
            out_valid  <= 1'b0;
            out_symbol <= '0;
            err        <= 1'b0;
            if (in_valid) begin
                // A load always wins; any partial code and concurrent bit are dropped.
                code_q   <= code_table;
                len_q    <= code_len;
                acc_q    <= '0;
                cnt_q    <= '0;
                state_q  <= RUN;
                table_ok <= 1'b1;
            end else if (state_q == RUN && bit_valid) begin
                if (hit) begin
                    out_valid  <= 1'b1;
                    out_symbol <= hit_idx;
                    acc_q      <= '0;
                    cnt_q      <= '0;
                end else if (cnt_n == 3'(HF_MAXLEN)) begin
                    err   <= 1'b1;
                    acc_q <= '0;
                    cnt_q <= '0;
                end else begin
                    acc_q <= acc_n;
                    cnt_q <= cnt_n;
                end
            end
        end
    end

endmodule

// File: tb/tb_hf_decoder.sv
// Directed bench for hf_decoder: reference table streams, error prefixes,
// reloads, gaps, reset recovery and table priority.
module tb_hf_decoder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [19:0] code_table;
    logic [14:0] code_len;
    logic        bit_valid;
    logic        bit_in;
    logic        out_valid;
    logic [2:0]  out_symbol;
    logic        err;
    logic        table_ok;

    int checks = 0;
    int errors = 0;

    localparam logic [19:0] REF_TABLE = 20'h026EF;
    localparam logic [14:0] REF_LEN   = 15'h14E4;

    hf_decoder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .code_table (code_table),
        .code_len   (code_len),
        .bit_valid  (bit_valid),
        .bit_in     (bit_in),
        .out_valid  (out_valid),
        .out_symbol (out_symbol),
        .err        (err),
        .table_ok   (table_ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, then land 1 time unit after the edge.
    task automatic step(input logic iv, input logic bv, input logic b);
        in_valid  = iv;
        bit_valid = bv;
        bit_in    = b;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        bit_valid = 1'b0;
        bit_in    = 1'b0;
    endtask

    task automatic load(input logic [19:0] t, input logic [14:0] l);
        code_table = t;
        code_len   = l;
        step(1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b0 || out_symbol !== 3'd0 || err !== 1'b0 || table_ok !== 1'b0) begin
            errors++;
            $display("FAIL reset: ov=%b sym=%0d err=%b tok=%b, expected all 0",
                     out_valid, out_symbol, err, table_ok);
        end
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_idle_ignore;
        logic [5:0] bits;
        bits = 6'b011110;
        for (int i = 5; i >= 0; i--) begin
            step(1'b0, 1'b1, bits[i]);
            checks++;
            if (out_valid !== 1'b0 || err !== 1'b0 || table_ok !== 1'b0) begin
                errors++;
                $display("FAIL idle_ignore bit%0d: ov=%b err=%b tok=%b, expected 0 0 0",
                         5 - i, out_valid, err, table_ok);
            end
        end
    endtask

    task automatic test_stream;
        logic [9:0] bits;
        logic [9:0] exp_v;
        logic [2:0] exp_sym [10];
        bits  = 10'b1001111110;
        exp_v = 10'b0110001001;    // pulses after bits 2, 3, 7, 10
        exp_sym = '{3'd0, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd4, 3'd0, 3'd0, 3'd2};
        load(REF_TABLE, REF_LEN);
        checks++;
        if (table_ok !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL load: tok=%b ov=%b, expected 1 0", table_ok, out_valid);
        end
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, bits[9-i]);
            checks++;
            if (out_valid !== exp_v[9-i] || out_symbol !== exp_sym[i] || err !== 1'b0) begin
                errors++;
                $display("FAIL stream bit%0d: ov=%b sym=%0d err=%b, expected %b %0d 0",
                         i + 1, out_valid, out_symbol, err, exp_v[9-i], exp_sym[i]);
            end
        end
        step(1'b0, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b0 || out_symbol !== 3'd0) begin
            errors++;
            $display("FAIL stream_gap: ov=%b sym=%0d, expected 0 0", out_valid, out_symbol);
        end
    endtask

    task automatic test_back_to_back;
        load(REF_TABLE, REF_LEN);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, 1'b0);
            checks++;
            if (out_valid !== 1'b1 || out_symbol !== 3'd0 || err !== 1'b0) begin
                errors++;
                $display("FAIL back_to_back %0d: ov=%b sym=%0d err=%b, expected 1 0 0",
                         i, out_valid, out_symbol, err);
            end
        end
    endtask

    task automatic test_err;
        load(REF_TABLE, 15'h14E0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b1);
            checks++;
            if (out_valid !== 1'b0 || err !== 1'b0) begin
                errors++;
                $display("FAIL err_prefix bit%0d: ov=%b err=%b, expected 0 0", i + 1, out_valid, err);
            end
        end
        step(1'b0, 1'b1, 1'b1);
        checks++;
        if (err !== 1'b1 || out_valid !== 1'b0 || out_symbol !== 3'd0) begin
            errors++;
            $display("FAIL err_pulse: err=%b ov=%b sym=%0d, expected 1 0 0", err, out_valid, out_symbol);
        end
        step(1'b0, 1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_symbol !== 3'd0 || err !== 1'b0) begin
            errors++;
            $display("FAIL err_resume: ov=%b sym=%0d err=%b, expected 1 0 0", out_valid, out_symbol, err);
        end
    endtask

    task automatic test_reload;
        load(REF_TABLE, REF_LEN);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        code_table = REF_TABLE;
        code_len   = REF_LEN;
        step(1'b1, 1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b0 || err !== 1'b0 || table_ok !== 1'b1) begin
            errors++;
            $display("FAIL reload_drop: ov=%b err=%b tok=%b, expected 0 0 1", out_valid, err, table_ok);
        end
        step(1'b0, 1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_symbol !== 3'd0) begin
            errors++;
            $display("FAIL reload_next: ov=%b sym=%0d, expected 1 0", out_valid, out_symbol);
        end
    endtask

    task automatic test_gaps;
        load(REF_TABLE, REF_LEN);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b1);
            for (int g = 0; g < 3; g++) begin
                step(1'b0, 1'b0, 1'b0);
                checks++;
                if (out_valid !== 1'b0 || err !== 1'b0) begin
                    errors++;
                    $display("FAIL gaps bit%0d gap%0d: ov=%b err=%b, expected 0 0", i + 1, g, out_valid, err);
                end
            end
        end
        step(1'b0, 1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_symbol !== 3'd3 || err !== 1'b0) begin
            errors++;
            $display("FAIL gaps_final: ov=%b sym=%0d err=%b, expected 1 3 0", out_valid, out_symbol, err);
        end
    endtask

    task automatic test_reset_mid;
        logic [3:0] bits;
        bits = 4'b1110;
        load(REF_TABLE, REF_LEN);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        rst_n = 1'b0;
        step(1'b0, 1'b1, 1'b0);
        rst_n = 1'b1;
        checks++;
        if (out_valid !== 1'b0 || out_symbol !== 3'd0 || err !== 1'b0 || table_ok !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: ov=%b sym=%0d err=%b tok=%b, expected all 0",
                     out_valid, out_symbol, err, table_ok);
        end
        for (int i = 3; i >= 0; i--) begin
            step(1'b0, 1'b1, bits[i]);
            checks++;
            if (out_valid !== 1'b0 || err !== 1'b0 || table_ok !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_ignore bit%0d: ov=%b err=%b tok=%b, expected 0 0 0",
                         4 - i, out_valid, err, table_ok);
            end
        end
        load(REF_TABLE, REF_LEN);
        step(1'b0, 1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_symbol !== 3'd0) begin
            errors++;
            $display("FAIL reset_mid_reload: ov=%b sym=%0d, expected 1 0", out_valid, out_symbol);
        end
    endtask

    task automatic test_priority;
        // a and b both coded "1" with length 1: index 0 must win.
        load(20'h11000, 15'h1200);
        step(1'b0, 1'b1, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_symbol !== 3'd0) begin
            errors++;
            $display("FAIL priority: ov=%b sym=%0d, expected 1 0", out_valid, out_symbol);
        end
        // Length 5 on a makes it unused, so b takes the same bit.
        load(20'h11000, 15'h5200);
        step(1'b0, 1'b1, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_symbol !== 3'd1) begin
            errors++;
            $display("FAIL unused_len5: ov=%b sym=%0d, expected 1 1", out_valid, out_symbol);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        bit_valid  = 1'b0;
        bit_in     = 1'b0;
        code_table = '0;
        code_len   = '0;
        test_reset;
        test_idle_ignore;
        test_stream;
        test_back_to_back;
        test_err;
        test_reload;
        test_gaps;
        test_reset_mid;
        test_priority;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
